mem_rw_ctrl_k2: RTL
===================

# mem_rw_ctrl_k2

Memory read/write-back controller for the radix-2 (k2) NTT datapath. It sits directly downstream of the k2 address-generation top. It consumes the per-cycle bank/memory-address pairs and issues read requests to the banked coefficient memory. It replays the same addresses as write-back requests once the butterfly result returns, then signals stage/transform completion after the pipeline drains.

## Interface
Parameters:
- RD_LAT, 1: memory read latency in cycles (read request to data valid).
- BFU_LAT, 6: butterfly latency in cycles (input data to result).
- WB_DLY, RD_LAT+BFU_LAT: derived; cycles from rd_en to the matching wr_en. Range 2..32.

Ports. Widths use `MA_width` and `BANK_width` from define.svh.
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- BN_MA_out_en_k2  in  1  address pair valid this cycle.
- MA0_idx_k2, MA1_idx_k2  in  `MA_width`  memory addresses of the butterfly operands.
- BN0_idx_k2, BN1_idx_k2  in  `BANK_width`  bank indices of the operands.
- l_AGU_out_k2  in  3  current stage index.
- AGU_done_out_k2  in  1  single-cycle pulse; the last pair was issued this cycle or earlier.
- rd_en  out  1  read request.
- rd_ma0, rd_ma1  out  `MA_width`  read addresses.
- rd_bn0, rd_bn1  out  `BANK_width`  read banks.
- wr_en  out  1  write-back request.
- wr_ma0, wr_ma1, wr_bn0, wr_bn1  out  as above  write-back addresses/banks.
- wr_l  out  3  stage tag of the write-back.
- busy  out  1  high in RUN or DRAIN.
- ntt_done_k2  out  1  one-cycle completion pulse.
- hazard_err  out  1  sticky read-after-write hazard flag.

## Operation
- FSM states:
  - IDLE:
    - BN_MA_out_en_k2=1 → RUN; hazard_err is cleared on this transition.
    - AGU_done_out_k2=1 without enable → DRAIN.
  - RUN:
    - AGU_done_out_k2=1 → DRAIN. An enable in the same cycle is accepted as the final request.
  - DRAIN: the delay line has no valid entries and no write is pending → DONE.
  - DONE: ntt_done_k2=1 for exactly one cycle → IDLE.
- Read issue: every cycle BN_MA_out_en_k2=1 in IDLE or RUN, the inputs are registered to the rd_* outputs and rd_en is set. Both operand addresses are forwarded unmodified.
- Enable in DRAIN or DONE is a protocol violation: the read is still issued and tracked, and hazard_err is set.
- Delay line: WB_DLY-stage shift register of {valid, ma0, ma1, bn0, bn1, l}, loaded with the rd_* payload, shifted every cycle with no stall. The tail drives wr_*, and wr_en equals the tail valid.
- Hazard check: on each read, compare (rd_bn, rd_ma) for both operands against both operands of every valid delay-line entry.
  - Any match (a read of a location whose write-back is outstanding) sets hazard_err.
  - The read still proceeds.
- Outputs with wr_en=0 / rd_en=0 hold their last values. Consumers must ignore them.
- Reset: all outputs 0, FSM in IDLE, delay line valids cleared. Reset mid-operation discards in-flight write-backs and produces no ntt_done_k2.

## Timing
- Read latency: input enable sampled at edge N, rd_en high in cycle N+1.
- Write latency: wr_en for that request is high in cycle N+1+WB_DLY.
- Back-to-back enables produce back-to-back rd_en and back-to-back wr_en with no bubbles. Throughput is one pair per cycle.
- Completion: ntt_done_k2 is high in the cycle after the last wr_en cycle.
  - If AGU_done_out_k2 arrives with an empty delay line, ntt_done_k2 is high 2 cycles after the done pulse (DRAIN, then DONE).
- busy rises with rd_en of the first request and falls with ntt_done_k2.

## Structure
- Shared package `ntt_k2_pkg`:
  - FSM state enum.
  - Struct `wb_entry_t` {valid, ma0, ma1, bn0, bn1, l}.
  - Default constants RD_LAT_DEF and BFU_LAT_DEF.
- Sub-module `wb_delay_line_k2`: parameterised shift register of `wb_entry_t`. It exposes all entries for the hazard compare and an any_valid flag.
- The FSM and hazard compare stay in the top.

## Test plan
- Single pair MA0=3, MA1=7, BN0=0, BN1=1, l=2, enable at edge 0 → rd_en in cycle 1 with those values, wr_en in cycle 8 with wr_l=2; done pulse at edge 1 → ntt_done_k2 in cycle 9.
- Burst of 16 consecutive pairs (MA0=i, MA1=i+8) → 16 contiguous rd_en cycles, then 16 contiguous wr_en cycles 7 cycles later, in order, with no hazard_err.
- AGU_done_out_k2 asserted together with the final enable → that pair is read and written back; ntt_done_k2 follows its wr_en by 1 cycle.
- Re-read of (bank 1, MA 5) 3 cycles after its first read → hazard_err=1 until the next IDLE→RUN transition.
- rst pulse while 4 writes are in flight → all outputs 0 next cycle, no wr_en and no ntt_done_k2 afterward.
- AGU_done_out_k2 with no prior enable → ntt_done_k2 2 cycles later; busy high in DRAIN only.

Source files
------------

// File: rtl/ntt_k2_pkg.sv
// Shared types and defaults for the k2 NTT memory read/write-back path.
// Address/bank widths mirror MA_width / BANK_width of the legacy define.svh.
package ntt_k2_pkg;

   localparam int unsigned MA_W        = 8;
   localparam int unsigned BN_W        = 1;
   localparam int unsigned RD_LAT_DEF  = 1;
   localparam int unsigned BFU_LAT_DEF = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic            valid;
      logic [MA_W-1:0] ma0;
      logic [MA_W-1:0] ma1;
      logic [BN_W-1:0] bn0;
      logic [BN_W-1:0] bn1;
      logic [2:0]      l;
   } wb_entry_t;

   // True when (bn, ma) names either operand location of entry e.
   function automatic logic op_hit(input logic [BN_W-1:0] bn,
                                   input logic [MA_W-1:0] ma,
                                   input wb_entry_t       e);
      return ((bn == e.bn0) && (ma == e.ma0)) || ((bn == e.bn1) && (ma == e.ma1));
   endfunction

endpackage

// File: rtl/wb_delay_line_k2.sv
// Fixed-latency shift register carrying read payloads to their write-back slot.
// Every entry is exposed so the top can check new reads against outstanding writes.
module wb_delay_line_k2
   import ntt_k2_pkg::*;
#(
   parameter int unsigned DEPTH = RD_LAT_DEF + BFU_LAT_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  wb_entry_t              in_i,
   output wb_entry_t [DEPTH-1:0]  entry_o,
   output logic                   any_valid_o
);

   wb_entry_t [DEPTH-1:0] stage_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '0;
      end else begin
         stage_q[0] <= in_i;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   always_comb begin
      any_valid_o = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         any_valid_o = any_valid_o | stage_q[i].valid;
      end
   end

   assign entry_o = stage_q;

endmodule

// File: rtl/mem_rw_ctrl_k2.sv
// k2 memory read / write-back controller: registers AGU address pairs as reads,
// replays them as write-backs WB_DLY cycles later and flags read-after-write hazards.
module mem_rw_ctrl_k2
   import ntt_k2_pkg::*;
#(
   parameter int unsigned RD_LAT  = RD_LAT_DEF,
   parameter int unsigned BFU_LAT = BFU_LAT_DEF,
   parameter int unsigned WB_DLY  = RD_LAT + BFU_LAT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            BN_MA_out_en_k2,
   input  logic [MA_W-1:0] MA0_idx_k2,
   input  logic [MA_W-1:0] MA1_idx_k2,
   input  logic [BN_W-1:0] BN0_idx_k2,
   input  logic [BN_W-1:0] BN1_idx_k2,
   input  logic [2:0]      l_AGU_out_k2,
   input  logic            AGU_done_out_k2,
   output logic            rd_en,
   output logic [MA_W-1:0] rd_ma0,
   output logic [MA_W-1:0] rd_ma1,
   output logic [BN_W-1:0] rd_bn0,
   output logic [BN_W-1:0] rd_bn1,
   output logic            wr_en,
   output logic [MA_W-1:0] wr_ma0,
   output logic [MA_W-1:0] wr_ma1,
   output logic [BN_W-1:0] wr_bn0,
   output logic [BN_W-1:0] wr_bn1,
   output logic [2:0]      wr_l,
   output logic            busy,
   output logic            ntt_done_k2,
   output logic            hazard_err
);

   state_e                 state_q, state_d;
   wb_entry_t              req;
   wb_entry_t              rd_q;
   wb_entry_t              wr_q;
   wb_entry_t [WB_DLY-1:0] line;
   logic                   any_valid;
   logic                   hit;
   logic                   start;
   logic                   viol;
   logic                   hazard_q, hazard_d;

   always_comb begin
      req.valid = BN_MA_out_en_k2;
      req.ma0   = MA0_idx_k2;
      req.ma1   = MA1_idx_k2;
      req.bn0   = BN0_idx_k2;
      req.bn1   = BN1_idx_k2;
      req.l     = l_AGU_out_k2;
   end

   // Line is loaded alongside the rd_* registers; the wr_* register adds the last cycle.
   wb_delay_line_k2 #(
      .DEPTH (WB_DLY)
   ) u_line (
      .clk         (clk),
      .rst         (rst),
      .in_i        (req),
      .entry_o     (line),
      .any_valid_o (any_valid)
   );

   always_comb begin
      hit = 1'b0;
      for (int unsigned i = 0; i < WB_DLY; i++) begin
         if (line[i].valid &&
             (op_hit(req.bn0, req.ma0, line[i]) || op_hit(req.bn1, req.ma1, line[i]))) begin
            hit = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (BN_MA_out_en_k2) begin
               start   = 1'b1;
               state_d = AGU_done_out_k2 ? ST_DRAIN : ST_RUN;
            end else if (AGU_done_out_k2) begin
               state_d = ST_DRAIN;
            end
         end
         ST_RUN:   if (AGU_done_out_k2) state_d = ST_DRAIN;
         ST_DRAIN: if (!any_valid && !BN_MA_out_en_k2) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      viol     = BN_MA_out_en_k2 && ((state_q == ST_DRAIN) || (state_q == ST_DONE));
      hazard_d = (start ? 1'b0 : hazard_q) | (BN_MA_out_en_k2 & hit) | viol;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rd_q     <= '0;
         wr_q     <= '0;
         hazard_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         hazard_q <= hazard_d;
         if (req.valid) rd_q <= req;
         else           rd_q.valid <= 1'b0;
         if (line[WB_DLY-1].valid) wr_q <= line[WB_DLY-1];
         else                      wr_q.valid <= 1'b0;
      end
   end

   assign rd_en       = rd_q.valid;
   assign rd_ma0      = rd_q.ma0;
   assign rd_ma1      = rd_q.ma1;
   assign rd_bn0      = rd_q.bn0;
   assign rd_bn1      = rd_q.bn1;
   assign wr_en       = wr_q.valid;
   assign wr_ma0      = wr_q.ma0;
   assign wr_ma1      = wr_q.ma1;
   assign wr_bn0      = wr_q.bn0;
   assign wr_bn1      = wr_q.bn1;
   assign wr_l        = wr_q.l;
   assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign ntt_done_k2 = (state_q == ST_DONE);
   assign hazard_err  = hazard_q;

endmodule
